// File: rtl/gc_cursor_regs_if.sv
// Register-bus bundle between the slave decode and gc_cursor_regs: single-cycle
// writes with byte enables, combinational read data.
interface gc_cursor_regs_if #(
    parameter int ADDR_W = 12
);
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic [31:0]       rd;

    modport master (output we, be, addr, wd, input rd);
    modport slave  (input we, be, addr, wd, output rd);
endinterface

// File: rtl/gc_cursor_regs.sv
// Cursor register block: CPU-written shadow coordinates commit to the display-facing
// set on synchronised vsync or forced commit; writes take effect in one cycle, reads are combinational, never stalls.
module gc_cursor_regs #(
    parameter int NUM_CURSORS = 2,
    parameter int COORD_W     = 12,
    parameter int ADDR_W      = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    gc_cursor_regs_if.slave                bus,
    input  logic                           vsync,
    output logic [NUM_CURSORS*COORD_W-1:0] cursor_x,
    output logic [NUM_CURSORS*COORD_W-1:0] cursor_y,
    output logic [NUM_CURSORS-1:0]         cursor_en,
    output logic                           irq
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_FRAME  = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_INTEN  = ADDR_W'(32'h0C);

    // Address decode
    logic [ADDR_W-1:0]      waddr;
    logic                   wr;
    logic                   sel_ctrl;
    logic                   sel_status;
    logic                   sel_frame;
    logic                   sel_inten;
    logic [NUM_CURSORS-1:0] sel_x;
    logic [NUM_CURSORS-1:0] sel_y;
    logic [31:0]            bmask;
    logic                   unused_bits;

    // Control / status state
    logic        shadow_en;
    logic        st_vs;
    logic        st_pend;
    logic        st_cmt;
    logic [31:0] frame_cnt;
    logic        ie_vs;
    logic        ie_cmt;

    // vsync synchroniser and commit
    logic s1;
    logic s2;
    logic s3;
    logic vs_pulse;
    logic force_commit;
    logic commit;
    logic status_clr;
    logic cursor_wr;

    // Cursor state
    logic [COORD_W-1:0]     sh_x  [NUM_CURSORS];
    logic [COORD_W-1:0]     sh_y  [NUM_CURSORS];
    logic [NUM_CURSORS-1:0] sh_en;
    logic [COORD_W-1:0]     act_x [NUM_CURSORS];
    logic [COORD_W-1:0]     act_y [NUM_CURSORS];
    logic [NUM_CURSORS-1:0] act_en;
    logic [COORD_W-1:0]     nx    [NUM_CURSORS];
    logic [COORD_W-1:0]     ny    [NUM_CURSORS];
    logic [NUM_CURSORS-1:0] nen;
    logic [31:0]            rd_w;

    assign waddr      = {bus.addr[ADDR_W-1:2], 2'b00};
    assign wr         = bus.we & (|bus.be);
    assign sel_ctrl   = (waddr == A_CTRL);
    assign sel_status = (waddr == A_STATUS);
    assign sel_frame  = (waddr == A_FRAME);
    assign sel_inten  = (waddr == A_INTEN);
    assign bmask      = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
    assign unused_bits = ^{bus.addr[1:0], bus.wd, bmask};

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NUM_CURSORS; i++) begin
            sel_x[i] = (waddr == ADDR_W'(16 + 8 * i));
            sel_y[i] = (waddr == ADDR_W'(20 + 8 * i));
        end
    end

    assign vs_pulse     = s2 & ~s3;
    assign force_commit = wr & sel_ctrl & bus.be[0] & bus.wd[1];
    assign commit       = (vs_pulse & shadow_en) | force_commit;
    assign status_clr   = wr & sel_status & bus.be[0];
    assign cursor_wr    = wr & ((|sel_x) | (|sel_y));

    // Byte-merged next shadow values; bits above COORD_W are not stored
    always_comb begin
        nen = sh_en;
        for (int i = 0; i < NUM_CURSORS; i++) begin
            nx[i]  = (bus.wd[COORD_W-1:0] & bmask[COORD_W-1:0]) | (sh_x[i] & ~bmask[COORD_W-1:0]);
            ny[i]  = (bus.wd[COORD_W-1:0] & bmask[COORD_W-1:0]) | (sh_y[i] & ~bmask[COORD_W-1:0]);
            nen[i] = bmask[31] ? bus.wd[31] : sh_en[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= vsync;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Hardware set wins over a same-cycle W1C or write-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_en <= 1'b1;
            st_vs     <= 1'b0;
            st_pend   <= 1'b0;
            st_cmt    <= 1'b0;
            frame_cnt <= '0;
            ie_vs     <= 1'b0;
            ie_cmt    <= 1'b0;
        end else begin
            if (wr && sel_ctrl && bus.be[0]) begin
                shadow_en <= bus.wd[0];
            end
            if (wr && sel_inten && bus.be[0]) begin
                ie_vs  <= bus.wd[0];
                ie_cmt <= bus.wd[2];
            end
            st_vs     <= vs_pulse | (st_vs & ~(status_clr & bus.wd[0]));
            st_cmt    <= commit | (st_cmt & ~(status_clr & bus.wd[2]));
            st_pend   <= (cursor_wr & shadow_en) | (st_pend & ~commit);
            frame_cnt <= ((wr && sel_frame) ? 32'd0 : frame_cnt) + {31'd0, vs_pulse};
        end
    end

    // A commit copies the pre-edge shadow, so a same-edge write lands only in the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CURSORS; i++) begin
                sh_x[i]  <= '0;
                sh_y[i]  <= '0;
                act_x[i] <= '0;
                act_y[i] <= '0;
            end
            sh_en  <= '0;
            act_en <= '0;
        end else begin
            for (int i = 0; i < NUM_CURSORS; i++) begin
                if (wr && sel_x[i]) begin
                    sh_x[i]  <= nx[i];
                    sh_en[i] <= nen[i];
                end
                if (wr && sel_y[i]) begin
                    sh_y[i] <= ny[i];
                end
                if (commit) begin
                    act_x[i]  <= sh_x[i];
                    act_y[i]  <= sh_y[i];
                    act_en[i] <= sh_en[i];
                end else if (!shadow_en) begin
                    if (wr && sel_x[i]) begin
                        act_x[i]  <= nx[i];
                        act_en[i] <= nen[i];
                    end
                    if (wr && sel_y[i]) begin
                        act_y[i] <= ny[i];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_w = '0;
        if (sel_ctrl) begin
            rd_w[0] = shadow_en;
        end
        if (sel_status) begin
            rd_w[2:0] = {st_cmt, st_pend, st_vs};
        end
        if (sel_frame) begin
            rd_w = frame_cnt;
        end
        if (sel_inten) begin
            rd_w[0] = ie_vs;
            rd_w[2] = ie_cmt;
        end
        for (int i = 0; i < NUM_CURSORS; i++) begin
            if (sel_x[i]) begin
                rd_w[COORD_W-1:0] = sh_x[i];
                rd_w[31]          = sh_en[i];
            end
            if (sel_y[i]) begin
                rd_w[COORD_W-1:0] = sh_y[i];
            end
        end
    end

    assign bus.rd = rd_w;

    for (genvar g = 0; g < NUM_CURSORS; g++) begin : g_out
        assign cursor_x[g*COORD_W +: COORD_W] = act_x[g];
        assign cursor_y[g*COORD_W +: COORD_W] = act_y[g];
    end
    assign cursor_en = act_en;

    assign irq = (st_vs & ie_vs) | (st_cmt & ie_cmt);

endmodule

// File: tb/tb_gc_cursor_regs.sv
// Scoreboard bench for gc_cursor_regs: expectations are queued as stimulus is
// applied and popped when the corresponding register or output is sampled.
module tb_gc_cursor_regs;
    localparam int NC = 2;
    localparam int CW = 12;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            vsync = 1'b0;
    logic [NC*CW-1:0] cursor_x;
    logic [NC*CW-1:0] cursor_y;
    logic [NC-1:0]   cursor_en;
    logic            irq;

    gc_cursor_regs_if #(.ADDR_W(AW)) bus ();

    gc_cursor_regs #(.NUM_CURSORS(NC), .COORD_W(CW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .vsync     (vsync),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .cursor_en (cursor_en),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop_check(input logic [31:0] act);
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, act, e);
    endtask

    function automatic logic [31:0] cx(input int i);
        return 32'(cursor_x[i*CW +: CW]);
    endfunction

    function automatic logic [31:0] cy(input int i);
        return 32'(cursor_y[i*CW +: CW]);
    endfunction

    // All tasks start and end 1 time unit after a rising edge
    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.wd   = d;
        bus.be   = b;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        bus.be = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string tag, input logic [AW-1:0] a, input logic [31:0] e);
        sb_push(tag, e);
        bus.addr = a;
        @(negedge clk);
        sb_pop_check(bus.rd);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] act, input logic [31:0] e);
        sb_push(tag, e);
        sb_pop_check(act);
    endtask

    // Raise vsync and stop inside the cycle where the synchronised pulse is high
    task automatic vsync_to_pulse();
        vsync = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.we   = 1'b0;
        bus.be   = 4'h0;
        bus.addr = '0;
        bus.wd   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        expect_rd("rst_ctrl",   12'h000, 32'h1);
        expect_rd("rst_status", 12'h004, 32'h0);
        expect_rd("rst_frame",  12'h008, 32'h0);
        expect_rd("rst_inten",  12'h00C, 32'h0);
        for (int a = 16; a < 32; a += 4) expect_rd("rst_cursor", 12'(a), 32'h0);
        expect_rd("rst_unmapped", 12'h050, 32'h0);
        expect_out("rst_cx",  32'(cursor_x), 32'h0);
        expect_out("rst_cy",  32'(cursor_y), 32'h0);
        expect_out("rst_en",  32'(cursor_en), 32'h0);
        expect_out("rst_irq", 32'(irq), 32'h0);

        // Shadowed write then vsync commit
        wr(12'h018, 32'h8000_0123, 4'hF);
        expect_rd("curx1_rb", 12'h018, 32'h8000_0123);
        expect_rd("pend_set", 12'h004, 32'h2);
        expect_out("cx1_hold", cx(1), 32'h0);
        expect_out("en_hold", 32'(cursor_en), 32'h0);
        vsync = 1'b1;
        idle(3);
        expect_out("cx1_commit", cx(1), 32'h123);
        expect_out("en_commit", 32'(cursor_en), 32'h2);
        expect_rd("status_commit", 12'h004, 32'h5);
        expect_rd("frame_1", 12'h008, 32'h1);
        idle(4);
        expect_rd("frame_no_repeat", 12'h008, 32'h1);
        vsync = 1'b0;
        idle(3);
        wr(12'h004, 32'h5, 4'h1);
        expect_rd("status_w1c", 12'h004, 32'h0);

        // Cursor write in the same cycle as the commit
        vsync_to_pulse();
        wr(12'h014, 32'h456, 4'hF);
        expect_out("cy0_old", cy(0), 32'h0);
        expect_rd("cury0_rb", 12'h014, 32'h456);
        expect_rd("status_coinc", 12'h004, 32'h7);
        expect_rd("frame_2", 12'h008, 32'h2);
        vsync = 1'b0;
        idle(3);
        vsync = 1'b1;
        idle(3);
        expect_out("cy0_commit", cy(0), 32'h456);
        expect_out("cx1_keep", cx(1), 32'h123);
        expect_rd("status_pend_clr", 12'h004, 32'h5);
        expect_rd("frame_3", 12'h008, 32'h3);
        vsync = 1'b0;
        idle(3);
        wr(12'h004, 32'h5, 4'h1);

        // Direct mode, byte enables and forced commit
        wr(12'h000, 32'h0, 4'h1);
        expect_rd("ctrl_off", 12'h000, 32'h0);
        wr(12'h010, 32'h7FF, 4'b0001);
        expect_out("cx0_direct", cx(0), 32'h0FF);
        expect_rd("curx0_be", 12'h010, 32'h0FF);
        expect_rd("status_no_pend", 12'h004, 32'h0);
        wr(12'h000, 32'h1, 4'h1);
        wr(12'h010, 32'h200, 4'hF);
        expect_out("cx0_pre_force", cx(0), 32'h0FF);
        wr(12'h000, 32'h3, 4'h1);
        expect_out("cx0_force", cx(0), 32'h200);
        expect_rd("status_force", 12'h004, 32'h4);
        expect_rd("ctrl_force_rd0", 12'h000, 32'h1);
        wr(12'h010, 32'hFFF, 4'h0);
        expect_rd("be0_noop", 12'h010, 32'h200);
        expect_rd("be0_no_pend", 12'h004, 32'h4);
        wr(12'h004, 32'h4, 4'h1);

        // Interrupts
        wr(12'h00C, 32'hFFFF_FFFF, 4'hF);
        expect_rd("inten_mask", 12'h00C, 32'h5);
        wr(12'h00C, 32'h1, 4'h1);
        expect_out("irq_idle", 32'(irq), 32'h0);
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
        expect_out("irq_vs", 32'(irq), 32'h1);
        expect_rd("frame_4", 12'h008, 32'h4);
        idle(3);
        wr(12'h004, 32'h1, 4'h1);
        expect_out("irq_clr", 32'(irq), 32'h0);
        expect_rd("status_vs_clr", 12'h004, 32'h4);
        vsync_to_pulse();
        wr(12'h004, 32'h1, 4'h1);
        expect_out("irq_set_wins", 32'(irq), 32'h1);
        expect_rd("status_set_wins", 12'h004, 32'h5);
        vsync = 1'b0;
        idle(3);
        vsync_to_pulse();
        wr(12'h008, 32'h0, 4'b0010);
        expect_rd("frame_clr_vs", 12'h008, 32'h1);
        vsync = 1'b0;
        idle(3);
        wr(12'h00C, 32'h4, 4'h1);
        wr(12'h004, 32'h5, 4'h1);
        expect_out("irq_cmt_idle", 32'(irq), 32'h0);
        wr(12'h000, 32'h3, 4'h1);
        expect_out("irq_cmt", 32'(irq), 32'h1);
        wr(12'h004, 32'h4, 4'h1);
        expect_out("irq_cmt_clr", 32'(irq), 32'h0);

        // Frame counter wrap
        force dut.frame_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt;
        expect_rd("frame_preload", 12'h008, 32'hFFFF_FFFF);
        vsync = 1'b1;
        idle(3);
        expect_rd("frame_wrap", 12'h008, 32'h0);
        vsync = 1'b0;
        idle(3);
        wr(12'h004, 32'h5, 4'h1);

        // Async reset in the commit cycle, vsync still high at release
        wr(12'h010, 32'h3AB, 4'hF);
        vsync_to_pulse();
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("mid_rst_cx", 32'(cursor_x), 32'h0);
        expect_out("mid_rst_cy", 32'(cursor_y), 32'h0);
        expect_out("mid_rst_en", 32'(cursor_en), 32'h0);
        expect_out("mid_rst_irq", 32'(irq), 32'h0);
        expect_rd("mid_rst_ctrl", 12'h000, 32'h1);
        expect_rd("mid_rst_curx0", 12'h010, 32'h0);
        rst_n = 1'b1;
        expect_rd("post_rst_inten", 12'h00C, 32'h0);
        idle(3);
        expect_rd("post_rst_frame", 12'h008, 32'h1);
        expect_rd("post_rst_status", 12'h004, 32'h5);
        expect_out("post_rst_cx", 32'(cursor_x), 32'h0);
        vsync = 1'b0;

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/gc_cursor_regs.md
Name: gc_cursor_regs

Overview:
- Parametrised, memory-mapped register block for the graphics controller. It holds N hardware cursors with double-buffered coordinates, plus control, status, interrupt-enable and frame-counter registers.
- CPU writes go to shadow registers. Shadows commit to the active (display-facing) registers on the synchronised vsync rising edge, or on a forced commit.
- Sits between the bus slave decode and the display pipeline.

Parameters:
- NUM_CURSORS, 2, number of cursors (1..8).
- COORD_W, 12, cursor coordinate width in bits (1..16).
- ADDR_W, 12, byte-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- we  in  1  write strobe, one transfer per cycle.
- be  in  4  byte enables for wd.
- addr  in  ADDR_W  byte address; addr[1:0] ignored.
- wd  in  32  write data.
- rd  out  32  read data, combinational from addr.
- vsync  in  1  asynchronous vertical-sync from the display timing domain.
- cursor_x  out  NUM_CURSORS*COORD_W  active X coordinates, cursor i at [i*COORD_W +: COORD_W].
- cursor_y  out  NUM_CURSORS*COORD_W  active Y coordinates, same packing.
- cursor_en  out  NUM_CURSORS  active enables.
- irq  out  1  level interrupt.

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: bit0 SHADOW_EN (R/W, reset 1); bit1 FORCE_COMMIT (write-1 pulse, reads 0).
  - 0x04 STATUS: bit0 VS (W1C), bit1 PEND (RO), bit2 CMT (W1C).
  - 0x08 FRAME_CNT: 32-bit, RO count; any write with any be set clears it.
  - 0x0C INT_EN: bits0,2 R/W; other bits read 0.
  - 0x10+8*i CURX[i]: [COORD_W-1:0] X, bit31 EN.
  - 0x14+8*i CURY[i]: [COORD_W-1:0] Y.
  - All unlisted bits read 0. Unmapped addresses read 0; writes to them are ignored.
- Byte enables: a write updates only bytes with be[k]=1. Status W1C bits use only byte 0. we with be=0 has no effect.
- Reads of CURX/CURY return shadow values, not active values.
- vsync synchronisation: 3-flop chain s1→s2→s3; vs_pulse = s2 & ~s3.
  - vsync rising before edge N gives vs_pulse high in the cycle after edge N+1; the commit occurs at edge N+2.
  - vs_pulse is one cycle per rising edge; a vsync held high causes no repeat.
- Commit events:
  - (vs_pulse & SHADOW_EN), or a CTRL write with be[0] & wd[1].
  - At that clock edge, all active registers load the shadow values present before the edge.
  - PEND clears and CMT sets.
- vs_pulse, regardless of SHADOW_EN: sets VS and increments FRAME_CNT (wraps 0xFFFFFFFF→0).
- SHADOW_EN=0: a cursor write updates shadow and active at the same edge; PEND is not set.
- SHADOW_EN=1: a cursor write updates shadow only and sets PEND.
- Simultaneous events:
  - Cursor write and commit at the same edge: active takes the pre-write shadow; the new shadow value is kept and PEND ends at 1.
  - W1C clear and hardware set at the same edge: set wins (bit = 1).
  - FRAME_CNT write-clear and vs_pulse at the same edge: FRAME_CNT = 1.
- irq = |(STATUS[0]&INT_EN[0], STATUS[2]&INT_EN[2]). Driven from registered state only; no combinational path from bus inputs.
- Reset (async, any time incl. mid-commit):
  - All shadow, active, STATUS, FRAME_CNT and INT_EN registers and the sync flops go to 0; CTRL = 0x1.
  - Outputs cursor_x/y/en = 0, irq = 0; rd reflects reset register contents.
  - A vsync that is already high at reset release produces a vs_pulse, since s3 resets to 0.

Test Plan:
- Reset, then read all registers → CTRL=0x1, others 0. cursor_x/y/en=0, irq=0.
- SHADOW_EN=1: write CURX[1]=0x8000_0123 → readback 0x8000_0123, PEND=1, cursor_x[1]/en[1] still 0. Raise vsync → 3 edges later cursor_x[1]=0x123, cursor_en[1]=1, PEND=0, CMT=1, VS=1, FRAME_CNT=1.
- Write CURY[0]=0x456 in the exact cycle vs_pulse is high → cursor_y[0] stays at old value 0, PEND=1. The next vsync commits 0x456.
- SHADOW_EN=0: write CURX[0]=0x7FF with be=4'b0001 → shadow and active both 0x0FF the following cycle, PEND=0. Then FORCE_COMMIT with SHADOW_EN=1 after writing CURX[0]=0x200 → active 0x200 next edge.
- INT_EN=0x1, pulse vsync → irq=1. Write STATUS=0x1 → irq=0. Repeat with W1C coinciding with vs_pulse → VS stays 1, irq stays 1.
- 0x1_0000_0000 frame wrap (preload via force-tested counter run or FRAME_CNT clear then count) and async reset asserted mid-commit → all outputs 0 within reset, CTRL=0x1 after.
